// File: rtl/rsa_session_ctrl.sv
// rsa_session_ctrl: owns one RSA request/response session between the UART
// and the serial_to_parallel / mon_exp / parallel_to_serial chain. It gates RX
// bytes into the frame assembler, sequences the compute and response launch,
// waits for the UART to drain, and flushes partial frames on inter-byte timeout.
module rsa_session_ctrl #(
    parameter int FRAME_BYTES    = 6,
    parameter int RESP_BYTES     = 2,
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int CW             = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_received,
    input  logic [7:0] uart_rx_byte,
    input  logic       uart_transmit,
    input  logic       uart_is_transmitting,
    input  logic       stp_valid,
    input  logic       mexp_stop,
    output logic       stp_rx_valid,
    output logic [7:0] stp_rx_byte,
    output logic       stp_flush,
    output logic       mexp_start,
    output logic       pts_start,
    output logic       busy,
    output logic [2:0] state,
    output logic [7:0] drop_cnt,
    output logic       timeout_err,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECV    = 3'd1,
        S_ARM     = 3'd2,
        S_COMPUTE = 3'd3,
        S_SEND    = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    // Counters compare against "last" values so the transition fires on the
    // same edge that the final byte / strobe is counted.
    localparam logic [7:0]    FRAME_LAST = 8'(FRAME_BYTES - 1);
    localparam logic [7:0]    RESP_LAST  = 8'(RESP_BYTES - 1);
    localparam logic [CW-1:0] TO_LIMIT   = CW'(TIMEOUT_CYCLES);

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_byte_cnt, w_byte_cnt_nxt;
    logic [7:0]    r_tx_cnt, w_tx_cnt_nxt;
    logic [CW-1:0] r_tcnt, w_tcnt_nxt;
    logic          r_rx_valid, w_rx_valid_nxt;
    logic [7:0]    r_rx_byte, w_rx_byte_nxt;
    logic          r_flush, w_flush_nxt;
    logic          r_mstart, w_mstart_nxt;
    logic          r_pstart, w_pstart_nxt;
    logic          r_done, w_done_nxt;
    logic          r_terr, w_terr_nxt;
    logic [7:0]    r_drop_cnt, w_drop_cnt_nxt;
    logic          w_accept;
    logic          w_drop;
    logic          w_expire;

    // Byte admission: only IDLE and RECV take bytes; every locked state drops them.
    always_comb begin
        w_accept = uart_received && ((r_state == S_IDLE) || (r_state == S_RECV));
        w_drop   = uart_received && ((r_state == S_ARM) || (r_state == S_COMPUTE) ||
                                     (r_state == S_SEND) || (r_state == S_DRAIN));
        w_expire = (r_tcnt == TO_LIMIT) && !w_accept;
    end

    // Next-state and next-output logic; pulses default low, holds default to current.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tcnt_nxt     = '0;
        w_rx_valid_nxt = 1'b0;
        w_rx_byte_nxt  = r_rx_byte;
        w_flush_nxt    = 1'b0;
        w_mstart_nxt   = 1'b0;
        w_pstart_nxt   = 1'b0;
        w_done_nxt     = 1'b0;
        w_terr_nxt     = r_terr;
        w_drop_cnt_nxt = r_drop_cnt;

        if (w_drop && (r_drop_cnt != 8'hFF)) begin
            w_drop_cnt_nxt = r_drop_cnt + 8'd1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_rx_valid_nxt = 1'b1;
                    w_rx_byte_nxt  = uart_rx_byte;
                    w_byte_cnt_nxt = 8'd1;
                    w_terr_nxt     = 1'b0;
                    w_state_nxt    = (FRAME_BYTES == 1) ? S_ARM : S_RECV;
                end
            end
            S_RECV: begin
                if (w_accept) begin
                    // A byte on the expiry cycle wins and restarts the idle count.
                    w_rx_valid_nxt = 1'b1;
                    w_rx_byte_nxt  = uart_rx_byte;
                    w_byte_cnt_nxt = r_byte_cnt + 8'd1;
                    if (r_byte_cnt == FRAME_LAST) begin
                        w_state_nxt = S_ARM;
                    end
                end else if (w_expire) begin
                    w_flush_nxt = 1'b1;
                    w_terr_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            S_ARM: begin
                // Operands arriving on the expiry cycle still launch the compute.
                if (stp_valid) begin
                    w_mstart_nxt = 1'b1;
                    w_state_nxt  = S_COMPUTE;
                end else if (w_expire) begin
                    w_flush_nxt = 1'b1;
                    w_terr_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            S_COMPUTE: begin
                if (mexp_stop) begin
                    w_pstart_nxt = 1'b1;
                    w_tx_cnt_nxt = 8'd0;
                    w_state_nxt  = S_SEND;
                end
            end
            S_SEND: begin
                if (uart_transmit) begin
                    w_tx_cnt_nxt = r_tx_cnt + 8'd1;
                    if (r_tx_cnt == RESP_LAST) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!uart_is_transmitting) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                // Unused encodings recover to IDLE.
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any session without pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_tx_cnt   <= '0;
            r_tcnt     <= '0;
            r_rx_valid <= 1'b0;
            r_rx_byte  <= '0;
            r_flush    <= 1'b0;
            r_mstart   <= 1'b0;
            r_pstart   <= 1'b0;
            r_done     <= 1'b0;
            r_terr     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_rx_byte  <= w_rx_byte_nxt;
            r_flush    <= w_flush_nxt;
            r_mstart   <= w_mstart_nxt;
            r_pstart   <= w_pstart_nxt;
            r_done     <= w_done_nxt;
            r_terr     <= w_terr_nxt;
            r_drop_cnt <= w_drop_cnt_nxt;
        end
    end

    assign stp_rx_valid = r_rx_valid;
    assign stp_rx_byte  = r_rx_byte;
    assign stp_flush    = r_flush;
    assign mexp_start   = r_mstart;
    assign pts_start    = r_pstart;
    assign done         = r_done;
    assign timeout_err  = r_terr;
    assign drop_cnt     = r_drop_cnt;
    assign state        = r_state;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_rsa_session_ctrl.sv
// Bench for rsa_session_ctrl: stimulus tasks push expected output pulses into
// a queue tagged with the cycle they must appear in; a monitor process pops and
// compares whenever the DUT raises any pulse output.
module tb_rsa_session_ctrl;

    localparam int FB = 6;
    localparam int RB = 2;
    localparam int TO = 100;

    localparam int IN_STPV  = 0;
    localparam int IN_MSTOP = 1;
    localparam int IN_TX    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_received = 1'b0;
    logic [7:0] uart_rx_byte = 8'h00;
    logic       uart_transmit = 1'b0;
    logic       uart_is_transmitting = 1'b0;
    logic       stp_valid = 1'b0;
    logic       mexp_stop = 1'b0;
    logic       stp_rx_valid;
    logic [7:0] stp_rx_byte;
    logic       stp_flush;
    logic       mexp_start;
    logic       pts_start;
    logic       busy;
    logic [2:0] state;
    logic [7:0] drop_cnt;
    logic       timeout_err;
    logic       done;

    rsa_session_ctrl #(
        .FRAME_BYTES(FB), .RESP_BYTES(RB), .TIMEOUT_CYCLES(TO), .CW(8)
    ) dut (
        .clk(clk), .rst(rst),
        .uart_received(uart_received), .uart_rx_byte(uart_rx_byte),
        .uart_transmit(uart_transmit), .uart_is_transmitting(uart_is_transmitting),
        .stp_valid(stp_valid), .mexp_stop(mexp_stop),
        .stp_rx_valid(stp_rx_valid), .stp_rx_byte(stp_rx_byte),
        .stp_flush(stp_flush), .mexp_start(mexp_start), .pts_start(pts_start),
        .busy(busy), .state(state), .drop_cnt(drop_cnt),
        .timeout_err(timeout_err), .done(done)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_RX, EV_FLUSH, EV_MSTART, EV_PSTART, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    // Reference model: a session accepts FB bytes, then refuses bytes until it
    // completes, times out, or is reset; refused bytes count up to 255.
    bit         m_locked = 1'b0;
    int         m_nb = 0;
    int         m_drops = 0;
    logic [7:0] last_b = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Expect a pulse in the cycle after the inputs driven now are sampled.
    task automatic push(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        e.kind = k; e.data = d; e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_received = 1'b1;
        uart_rx_byte  = b;
        if (!m_locked) begin
            push(EV_RX, b);
            last_b = b;
            m_nb++;
            if (m_nb == FB) begin
                m_locked = 1'b1;
                m_nb = 0;
            end
        end else if (m_drops < 255) begin
            m_drops++;
        end
        @(negedge clk);
        uart_received = 1'b0;
    endtask

    task automatic pulse_in(input int which, input bit expect_out);
        case (which)
            IN_STPV:  stp_valid = 1'b1;
            IN_MSTOP: mexp_stop = 1'b1;
            default:  uart_transmit = 1'b1;
        endcase
        if (expect_out) push((which == IN_STPV) ? EV_MSTART : EV_PSTART, 8'h00);
        @(negedge clk);
        stp_valid = 1'b0;
        mexp_stop = 1'b0;
        uart_transmit = 1'b0;
    endtask

    // Idle is long enough that the next event lands after the timeout flush.
    task automatic expect_timeout();
        ev_t e;
        e.kind = EV_FLUSH; e.data = 8'h00; e.cyc = cyc + TO + 1;
        exp_q.push_back(e);
        m_locked = 1'b0;
        m_nb = 0;
        idle(TO + 1);
        chk("timeout_state", int'(state), 0);
        chk("timeout_err_set", int'(timeout_err), 1);
    endtask

    task automatic collect(input int n, input int max_gap, input bit fixed);
        for (int i = 0; i < n; i++) begin
            send_byte(fixed ? 8'(8'h11 + i) : 8'($urandom_range(0, 255)));
            if (i < n - 1) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic finish_session(input int ndrop);
        chk("arm_state", int'(state), 2);
        chk("rx_byte_hold", int'(stp_rx_byte), int'(last_b));
        idle($urandom_range(0, 20));
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 255)));
        pulse_in(IN_STPV, 1'b1);
        chk("compute_state", int'(state), 3);
        idle($urandom_range(0, 10));
        repeat (ndrop) send_byte(8'($urandom_range(0, 255)));
        pulse_in(IN_TX, 1'b0);
        pulse_in(IN_STPV, 1'b0);
        pulse_in(IN_MSTOP, 1'b1);
        chk("send_state", int'(state), 4);
        uart_is_transmitting = 1'b1;
        for (int t = 0; t < RB; t++) begin
            idle($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 255)));
            pulse_in(IN_TX, 1'b0);
        end
        chk("drain_state", int'(state), 5);
        idle($urandom_range(0, 5));
        pulse_in(IN_MSTOP, 1'b0);
        uart_is_transmitting = 1'b0;
        push(EV_DONE, 8'h00);
        @(negedge clk);
        m_locked = 1'b0;
        chk("done_state", int'(state), 0);
        chk("done_busy", int'(busy), 0);
    endtask

    // Monitor: every pulse the DUT raises must match the queue head, in its cycle.
    initial begin
        forever begin
            int       nhigh;
            ev_kind_t k;
            ev_t      e;
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL missing_%s: got none expected cycle %0d (now %0d)",
                         e.kind.name(), e.cyc, cyc);
            end
            nhigh = int'(stp_rx_valid) + int'(stp_flush) + int'(mexp_start) +
                    int'(pts_start) + int'(done);
            k = stp_rx_valid ? EV_RX : stp_flush ? EV_FLUSH : mexp_start ? EV_MSTART :
                pts_start ? EV_PSTART : EV_DONE;
            if (nhigh > 1) begin
                checks++; errors++;
                $display("FAIL multi_pulse: got %0d pulses expected 1 (cycle %0d)", nhigh, cyc);
            end else if (nhigh == 1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL unexpected_%s: got pulse at cycle %0d expected none", k.name(), cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != k) begin
                        errors++;
                        $display("FAIL pulse_kind: got %s expected %s (cycle %0d)",
                                 k.name(), e.kind.name(), cyc);
                    end else if (k == EV_RX && e.data != stp_rx_byte) begin
                        errors++;
                        $display("FAIL rx_byte: got %02h expected %02h (cycle %0d)",
                                 stp_rx_byte, e.data, cyc);
                    end
                end
            end
        end
    end

    initial begin
        idle(3);
        chk("reset_outputs", int'({stp_rx_valid, stp_rx_byte, stp_flush, mexp_start, pts_start,
                                   busy, state, drop_cnt, timeout_err, done}), 0);
        rst = 1'b1;
        idle(2);

        // Nominal session with 0x11..0x16, then randomized sessions with drops.
        collect(FB, 3, 1'b1);
        finish_session(0);
        for (int s = 0; s < 4; s++) begin
            collect(FB, 40, 1'b0);
            finish_session($urandom_range(1, 5));
        end
        chk("drop_cnt_partial", int'(drop_cnt), m_drops);

        // Timeout in RECV after three bytes; the next byte clears the sticky flag.
        collect(3, 10, 1'b0);
        expect_timeout();
        send_byte(8'($urandom_range(0, 255)));
        chk("terr_cleared", int'(timeout_err), 0);
        chk("recv_state", int'(state), 1);

        // Byte on the exact expiry cycle is accepted and no flush occurs.
        collect(2, 10, 1'b0);
        idle(TO);
        send_byte(8'hA5);
        chk("race_state", int'(state), 1);
        chk("race_terr", int'(timeout_err), 0);
        collect(2, TO, 1'b0);
        chk("race_arm_state", int'(state), 2);

        // Timeout also applies while waiting for operands.
        expect_timeout();

        // Spurious strobes in IDLE and RECV have no effect.
        pulse_in(IN_MSTOP, 1'b0);
        pulse_in(IN_STPV, 1'b0);
        pulse_in(IN_TX, 1'b0);
        chk("spur_idle_state", int'(state), 0);
        collect(2, 5, 1'b0);
        pulse_in(IN_STPV, 1'b0);
        pulse_in(IN_MSTOP, 1'b0);
        chk("spur_recv_state", int'(state), 1);
        collect(4, 5, 1'b0);
        finish_session(0);

        // Lockout: 300 bytes during compute saturate drop_cnt at 255.
        collect(FB, 10, 1'b0);
        finish_session(300);
        chk("drop_cnt_sat", int'(drop_cnt), 255);
        chk("drop_cnt_model", int'(drop_cnt), m_drops);

        // Reset in the middle of SEND, then a fresh session.
        collect(FB, 10, 1'b0);
        pulse_in(IN_STPV, 1'b1);
        pulse_in(IN_MSTOP, 1'b1);
        uart_is_transmitting = 1'b1;
        pulse_in(IN_TX, 1'b0);
        chk("pre_reset_state", int'(state), 4);
        rst = 1'b0;
        @(negedge clk);
        m_locked = 1'b0; m_nb = 0; m_drops = 0;
        chk("midreset_outputs", int'({stp_rx_valid, stp_rx_byte, stp_flush, mexp_start, pts_start,
                                      busy, state, drop_cnt, timeout_err, done}), 0);
        rst = 1'b1;
        uart_is_transmitting = 1'b0;
        idle(2);
        collect(FB, 10, 1'b0);
        finish_session(2);
        chk("drop_cnt_after_reset", int'(drop_cnt), m_drops);

        idle(5);
        chk("leftover_expected", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
